sbox_round_ctrl: RTL and testbench

//   Sequencer for the team's shared 4-bit substitution unit (X[3:0] -> Y[3:0], combinational).

---
 rtl/sbox_round_ctrl.sv | 123 ++++++++++++
 tb/tb_sbox_round_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_round_ctrl.sv
// Sequencer that streams a word through an external 4-bit S-box one nibble per clock,
// for ROUNDS rounds, rotating the word left by one nibble between rounds.
module sbox_round_ctrl #(
   parameter int unsigned NIBBLES = 4,
   parameter int unsigned ROUNDS  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [4*NIBBLES-1:0]   din_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*NIBBLES-1:0]   dout_o,
   output logic [3:0]             sbox_x_o,
   input  logic [3:0]             sbox_y_i
);

   localparam int unsigned W     = 4 * NIBBLES;
   localparam int unsigned NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_MIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     work_q, work_d;
   logic [W-1:0]     dout_q, dout_d;
   logic [NIB_W-1:0] nib_q, nib_d;
   logic [RND_W-1:0] rnd_q, rnd_d;
   logic [3:0]       sbox_x_q, sbox_x_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W-1:0]     rot_c;

   // Rotate left by one nibble; degenerates to identity for a single nibble.
   always_comb begin
      rot_c = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         rot_c[4*((i+1) % NIBBLES) +: 4] = work_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dout_d  = dout_q;
      nib_d   = nib_q;
      rnd_d   = rnd_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               work_d  = din_i;
               nib_d   = '0;
               rnd_d   = '0;
               state_d = ST_SUB;
            end
         end
         ST_SUB: begin
            work_d[{nib_q, 2'b00} +: 4] = sbox_y_i;
            if (nib_q != LAST_NIB) begin
               nib_d = NIB_W'(nib_q + 1'b1);
            end else if (rnd_q != LAST_RND) begin
               nib_d   = '0;
               state_d = ST_MIX;
            end else begin
               dout_d  = work_d;
               state_d = ST_DONE;
            end
         end
         ST_MIX: begin
            work_d  = rot_c;
            rnd_d   = RND_W'(rnd_q + 1'b1);
            state_d = ST_SUB;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are precomputed from the next state so they leave the block registered.
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
      sbox_x_d = (state_d == ST_SUB) ? work_d[{nib_d, 2'b00} +: 4] : 4'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         dout_q   <= '0;
         nib_q    <= '0;
         rnd_q    <= '0;
         sbox_x_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         dout_q   <= dout_d;
         nib_q    <= nib_d;
         rnd_q    <= rnd_d;
         sbox_x_q <= sbox_x_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign dout_o   = dout_q;
   assign sbox_x_o = sbox_x_q;

endmodule

// File: tb/tb_sbox_round_ctrl.sv
// Bench for sbox_round_ctrl: a ROUNDS=1 and a ROUNDS=2 instance share stimulus and are
// checked every cycle against a word-level model of the substitution/rotation schedule.
module tb_sbox_round_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] din;

   logic [1:0]  busy_w;
   logic [1:0]  done_w;
   logic [15:0] dout_w [2];
   logic [3:0]  sx_w   [2];
   logic [3:0]  sy_w   [2];

   int tests;
   int fails;
   int cyc;

   // model state: per instance, active flag, cycle index since accept, captured word, result
   logic        act_m  [2];
   int          cnt_m  [2];
   logic [15:0] din_m  [2];
   logic [15:0] dout_m [2];

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'h7;  4'h1: return 4'h3;  4'h2: return 4'h6;  4'h3: return 4'hD;
         4'h4: return 4'h7;  4'h5: return 4'h2;  4'h6: return 4'h5;  4'h7: return 4'hC;
         4'h8: return 4'h8;  4'h9: return 4'h1;  4'hA: return 4'h4;  4'hB: return 4'hA;
         4'hC: return 4'h9;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hE;
      endcase
   endfunction

   assign sy_w[0] = sbox(sx_w[0]);
   assign sy_w[1] = sbox(sx_w[1]);

   sbox_round_ctrl #(.NIBBLES(4), .ROUNDS(1)) u_r1 (
      .clk(clk), .rst(rst), .start_i(start), .din_i(din),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .dout_o(dout_w[0]),
      .sbox_x_o(sx_w[0]), .sbox_y_i(sy_w[0])
   );

   sbox_round_ctrl #(.NIBBLES(4), .ROUNDS(2)) u_r2 (
      .clk(clk), .rst(rst), .start_i(start), .din_i(din),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .dout_o(dout_w[1]),
      .sbox_x_o(sx_w[1]), .sbox_y_i(sy_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] sub_nibs(input logic [15:0] w, input int n);
      logic [15:0] r;
      r = w;
      for (int p = 0; p < n; p++) r[4*p +: 4] = sbox(w[4*p +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] w);
      return {w[11:0], w[15:12]};
   endfunction

   // word held in the work register when nibble pos of round r is being presented
   function automatic logic [15:0] word_at(input logic [15:0] d, input int r, input int pos);
      logic [15:0] w;
      w = d;
      for (int k = 0; k < r; k++) w = rotl(sub_nibs(w, 4));
      return sub_nibs(w, pos);
   endfunction

   function automatic logic [15:0] result_of(input logic [15:0] d, input int rounds);
      logic [15:0] w;
      w = d;
      for (int k = 0; k < rounds; k++) begin
         w = sub_nibs(w, 4);
         if (k < rounds - 1) w = rotl(w);
      end
      return w;
   endfunction

   // instance i runs i+1 rounds; a request occupies rounds*(4+1) busy cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            act_m[i]  <= 1'b0;
            cnt_m[i]  <= 0;
            dout_m[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (act_m[i]) begin
               if (cnt_m[i] == (i + 1) * 5 - 1) begin
                  act_m[i] <= 1'b0;
               end else begin
                  cnt_m[i] <= cnt_m[i] + 1;
                  if (cnt_m[i] + 1 == (i + 1) * 5 - 1) dout_m[i] <= result_of(din_m[i], i + 1);
               end
            end else if (start) begin
               act_m[i] <= 1'b1;
               cnt_m[i] <= 0;
               din_m[i] <= din;
            end
         end
      end
   end

   task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, inst, cyc, act, exp);
      end
   endtask

   task automatic tick();
      logic [15:0] w;
      logic        eb, ed;
      logic [3:0]  ex;
      int          c, pos;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         eb = 1'b0; ed = 1'b0; ex = 4'h0;
         if (act_m[i]) begin
            c   = cnt_m[i];
            pos = c % 5;
            eb  = 1'b1;
            ed  = (c == (i + 1) * 5 - 1);
            if (pos < 4) begin
               w  = word_at(din_m[i], c / 5, pos);
               ex = w[4*pos +: 4];
            end
         end
         chk("busy",   i, 16'(busy_w[i]), 16'(eb));
         chk("done",   i, 16'(done_w[i]), 16'(ed));
         chk("sbox_x", i, 16'(sx_w[i]),   16'(ex));
         chk("dout",   i, dout_w[i],      dout_m[i]);
      end
   endtask

   // asynchronous reset asserted mid-cycle, outputs checked before any clock edge
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", i, 16'(busy_w[i]), 16'h0);
         chk("rst_done", i, 16'(done_w[i]), 16'h0);
         chk("rst_dout", i, dout_w[i],      16'h0);
         chk("rst_sbx",  i, 16'(sx_w[i]),   16'h0);
      end
      tick();
      rst = 1'b0;
   endtask

   // one-cycle START; latency counted in edges including the accepting one
   task automatic run_req(input logic [15:0] d, input bit repulse,
                          output int lat0, output int lat1, output int nd0, output int nd1);
      lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0;
      start = 1'b1;
      din   = d;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (done_w[0]) begin nd0++; if (lat0 < 0) lat0 = k; end
         if (done_w[1]) begin nd1++; if (lat1 < 0) lat1 = k; end
         start = (repulse && k == 2);
         din   = (repulse && k == 2) ? 16'hFFFF : 16'hA5A5;
      end
   endtask

   int l0, l1, n0, n1;
   int last0, last1, gap1, ndh0, ndh1;
   bit seen_busy1;

   initial begin
      tests = 0; fails = 0; cyc = 0;
      rst = 1'b0; start = 1'b0; din = 16'h0000;
      #1 rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // model pins
      chk("pin_r1", 0, result_of(16'h1234, 1), 16'h36D7);
      chk("pin_r2", 1, result_of(16'h1234, 2), 16'h50CD);

      run_req(16'h1234, 1'b0, l0, l1, n0, n1);
      chk("lat_r1",   0, 16'(l0), 16'd5);
      chk("lat_r2",   1, 16'(l1), 16'd10);
      chk("dout_lit", 0, dout_w[0], 16'h36D7);
      chk("dout_lit", 1, dout_w[1], 16'h50CD);
      chk("ndone",    0, 16'(n0), 16'd1);
      chk("ndone",    1, 16'(n1), 16'd1);

      run_req(16'h0000, 1'b0, l0, l1, n0, n1);
      chk("dout_zero", 0, dout_w[0], 16'h7777);
      chk("dout_zero", 1, dout_w[1], 16'hCCCC);

      run_req(16'h1234, 1'b1, l0, l1, n0, n1);
      chk("ign_dout",  1, dout_w[1], 16'h50CD);
      chk("ign_ndone", 1, 16'(n1), 16'd1);
      chk("ign_ndone", 0, 16'(n0), 16'd1);

      // abort a ROUNDS=2 request while it sits in its MIX cycle
      start = 1'b1; din = 16'h1234;
      for (int k = 1; k <= 5; k++) begin
         tick();
         start = 1'b0;
      end
      chk("mix_busy", 1, 16'(busy_w[1]), 16'h1);
      chk("mix_sbx",  1, 16'(sx_w[1]),   16'h0);
      async_reset();
      tick();
      run_req(16'h0000, 1'b0, l0, l1, n0, n1);
      chk("abort_ndone", 1, 16'(n1), 16'd1);
      chk("abort_dout",  1, dout_w[1], 16'hCCCC);
      chk("abort_lat",   1, 16'(l1), 16'd10);

      // START held high: back-to-back requests
      last0 = -1; last1 = -1; gap1 = 0; ndh0 = 0; ndh1 = 0; seen_busy1 = 1'b0;
      start = 1'b1; din = 16'h1234;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done_w[0]) begin
            if (last0 >= 0) chk("space_r1", 0, 16'(k - last0), 16'd6);
            last0 = k; ndh0++;
         end
         if (done_w[1]) begin
            if (last1 >= 0) chk("space_r2", 1, 16'(k - last1), 16'd11);
            last1 = k; ndh1++;
         end
         if (busy_w[1]) begin
            if (seen_busy1 && gap1 > 0) chk("idle_gap", 1, 16'(gap1), 16'd1);
            seen_busy1 = 1'b1;
            gap1 = 0;
         end else begin
            gap1++;
         end
      end
      start = 1'b0;
      chk("held_ndone", 0, 16'(ndh0), 16'd6);
      chk("held_ndone", 1, 16'(ndh1), 16'd3);
      for (int k = 0; k < 12; k++) tick();
      chk("held_idle", 1, 16'(busy_w[1]), 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
